fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the team's synchronous FIFO among NUM_REQ producers. It grants one requester at a time for a whole burst, which ends at that requester's last beat or at MAX_BURST beats. Data is forwarded beat-by-beat into the FIFO, and the FIFO full flag back-pressures the granted producer. The block sits directly in front of the FIFO write interface (wr/data_in/full).

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 128, data width; must equal the FIFO data width
MAX_BURST, 16, maximum beats per grant before forced release (1..256)
ID_W, $clog2(NUM_REQ), width of grant_id

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester beat valid
req_last  in  NUM_REQ  per-requester last beat of burst, qualified by req_valid
req_data  in  NUM_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
req_ready  out  NUM_REQ  per-requester beat accepted this cycle
fifo_full  in  1  FIFO full flag
fifo_wr  out  1  FIFO write strobe
fifo_data  out  WIDTH  FIFO write data
grant_id  out  ID_W  index of current or last granted requester
busy  out  1  high while in GRANT state
burst_trunc  out  1  one-cycle pulse: burst released by MAX_BURST, not by last

Behaviour:
- Reset (synchronous, checked first every cycle): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, busy=0, burst_trunc=0. req_ready=0, fifo_wr=0 and fifo_data=0 from the first cycle after reset is sampled.
- FSM states: IDLE, GRANT.
- IDLE:
  - req_ready=0, fifo_wr=0.
  - If any req_valid is high, select the first requester with valid high, searching from rr_ptr upward with wrap modulo NUM_REQ.
  - Register the winner in grant_id and clear beat_cnt. Next state is GRANT.
  - If no requester is valid, stay in IDLE.
- Arbitration latency: 1 cycle. A valid raised in cycle N can be written to the FIFO at the earliest in cycle N+1.
- GRANT, with g = grant_id:
  - req_ready[g] = !fifo_full; all other ready bits = 0. This is a combinational path from fifo_full.
  - fifo_wr = req_valid[g] & !fifo_full.
  - fifo_data = req_data[g] when fifo_wr is high, else 0.
  - A beat is a cycle with fifo_wr=1. Each beat increments beat_cnt (width $clog2(MAX_BURST+1)).
- Release: on a beat where req_last[g]=1, or where beat_cnt+1 == MAX_BURST:
  - Next state is IDLE and rr_ptr = (g+1) mod NUM_REQ.
  - If the release came from MAX_BURST and req_last[g]=0, burst_trunc=1 in the next cycle only.
  - The next grant therefore goes out at least 2 cycles after the final beat of the previous burst (1 idle bubble).
- fifo_full high in GRANT: no beat, beat_cnt holds, grant holds, data is not consumed. Requester g must hold its data (valid/ready handshake).
- Granted requester drops req_valid mid-burst: grant holds indefinitely with no timeout. Other requesters stall. This is the producer's responsibility.
- Requesters that are not granted: their ready bit is 0 and their data is ignored; they may change valid freely.
- MAX_BURST=1: every beat releases the grant. burst_trunc pulses on each beat that lacks last.
- Reset in GRANT: the in-flight burst is abandoned and no write occurs in the following cycle. rr_ptr returns to 0, so requester 0 has priority.
- rr_ptr wrap: after grant NUM_REQ-1, rr_ptr returns to 0.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,NUM_REQ-1,0,...

Test Plan:
- Single burst: req_valid[2]=1 for 3 beats, last on beat 3, FIFO not full -> grant_id=2 one cycle later; fifo_wr high for exactly 3 consecutive cycles with req_data[2] values; busy falls the cycle after the last beat; burst_trunc stays 0.
- Round-robin: all 4 requesters valid, each burst 2 beats with last -> grant order 0,1,2,3,0; exactly one idle cycle between bursts; FIFO receives 10 words in that order.
- Truncation: MAX_BURST=16, req0 streams 20 beats with no last -> 16 writes, burst_trunc pulses once; req1 (also valid) is granted next; req0 is re-granted later to finish its remaining 4 beats.
- Back-pressure: mid-burst, fifo_full=1 for 5 cycles -> fifo_wr=0 and req_ready=0 for those cycles, beat_cnt frozen, grant_id unchanged; after full clears, the remaining beats are written with no loss or duplication.
- Reset mid-burst: assert reset on beat 2 of a 4-beat burst from req3 -> fifo_wr=0 the next cycle, busy=0, grant_id=0; with req1 and req3 both valid after reset, req1 wins.
- Idle: no req_valid for 50 cycles -> fifo_wr, busy and all req_ready stay 0; state remains IDLE.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side handshake bundle for the FIFO write-port arbiter.
// The slave modport is the arbiter's view; master drives requests and the full flag.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 128
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_wr;
  logic [WIDTH-1:0]         fifo_data;

  modport master (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_wr, fifo_data
  );

  modport slave (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_wr, fifo_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among NUM_REQ
// producers; a grant lasts for a whole burst (last beat or MAX_BURST beats).
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 128,
  parameter int MAX_BURST = 16,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic            clk,
  input  logic            reset,
  fifo_wr_arbiter_if.slave bus,
  output logic [ID_W-1:0] grant_id,
  output logic            busy,
  output logic            burst_trunc
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W:0] MAX_CNT = (CNT_W + 1)'(MAX_BURST);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state_reg;
  logic [ID_W-1:0]  rr_ptr_reg;
  logic [ID_W-1:0]  grant_reg;
  logic [CNT_W-1:0] beat_cnt_reg;
  logic             busy_reg;
  logic             trunc_reg;

  logic [NUM_REQ-1:0] rot_valid;
  logic [ID_W-1:0]    rot_idx [NUM_REQ];
  logic [WIDTH-1:0]   req_word [NUM_REQ];
  logic [NUM_REQ-1:0] ready_vec;

  logic            any_valid;
  logic [ID_W-1:0] winner;
  logic            granted_valid;
  logic            granted_last;
  logic            beat;
  logic            cnt_hit;
  logic            release_now;
  logic [ID_W-1:0] next_ptr;

  // Slot gi of the rotated view is requester (rr_ptr + gi) mod NUM_REQ.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic [ID_W:0] sum;
      assign sum            = {1'b0, rr_ptr_reg} + (ID_W + 1)'(gi);
      assign rot_idx[gi]    = (sum >= (ID_W + 1)'(NUM_REQ)) ? ID_W'(sum - (ID_W + 1)'(NUM_REQ))
                                                            : ID_W'(sum);
      assign rot_valid[gi]  = bus.req_valid[rot_idx[gi]];
      assign req_word[gi]   = bus.req_data[gi*WIDTH +: WIDTH];
      assign ready_vec[gi]  = (state_reg == GRANT) && (grant_reg == ID_W'(gi)) && !bus.fifo_full;
    end
  endgenerate

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    any_valid = 1'b0;
    winner    = rr_ptr_reg;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_valid[i]) begin
        any_valid = 1'b1;
        winner    = rot_idx[i];
      end
    end
  end

  assign granted_valid = bus.req_valid[grant_reg];
  assign granted_last  = bus.req_last[grant_reg];
  assign beat          = (state_reg == GRANT) && granted_valid && !bus.fifo_full;
  assign cnt_hit       = (({1'b0, beat_cnt_reg} + 1'b1) == MAX_CNT);
  assign release_now   = beat && (granted_last || cnt_hit);
  assign next_ptr      = (grant_reg == ID_W'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;

  assign bus.req_ready = ready_vec;
  assign bus.fifo_wr   = beat;
  assign bus.fifo_data = beat ? req_word[grant_reg] : '0;

  assign grant_id    = grant_reg;
  assign busy        = busy_reg;
  assign burst_trunc = trunc_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      grant_reg    <= '0;
      beat_cnt_reg <= '0;
      busy_reg     <= 1'b0;
      trunc_reg    <= 1'b0;
    end else begin
      trunc_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            grant_reg    <= winner;
            beat_cnt_reg <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= GRANT;
          end
        end
        GRANT: begin
          if (beat) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
            if (release_now) begin
              state_reg  <= IDLE;
              busy_reg   <= 1'b0;
              rr_ptr_reg <= next_ptr;
              trunc_reg  <= !granted_last;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a burst-level reference model
// of the round-robin grant rules, with handshaking producers.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 128;
  localparam int MAX_BURST = 16;
  localparam int ID_W      = $clog2(NUM_REQ);

  logic            clk = 1'b0;
  logic            reset;
  logic [ID_W-1:0] grant_id;
  logic            busy;
  logic            burst_trunc;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .WIDTH    (WIDTH),
    .MAX_BURST(MAX_BURST),
    .ID_W     (ID_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .grant_id   (grant_id),
    .busy       (busy),
    .burst_trunc(burst_trunc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Reference model: which requester owns the port (-1 = none), whose turn
  // comes next, beats taken in the current burst, and the truncation pulse.
  int  m_owner    = -1;
  int  m_last_gid = 0;
  int  m_turn     = 0;
  int  m_beats    = 0;
  bit  m_trunc    = 1'b0;

  // Producers hold a beat until it is accepted.
  bit               p_valid [NUM_REQ];
  bit               p_last  [NUM_REQ];
  logic [WIDTH-1:0] p_data  [NUM_REQ];
  int               p_seq   [NUM_REQ];

  typedef struct {
    int cycles;
    int valid_pct;
    int last_pct;
    int full_pct;
    int reset_pct;
  } phase_t;

  // reset hold, idle, mixed traffic, truncation, back-pressure, all-valid, random resets
  phase_t phases [7] = '{
    '{3,   0,   0,  0,  100},
    '{50,  0,   0,  0,  0},
    '{400, 60,  30, 10, 0},
    '{300, 95,  0,  0,  0},
    '{300, 80,  20, 50, 0},
    '{200, 100, 50, 0,  0},
    '{400, 70,  25, 15, 3}
  };

  task automatic drive_bus();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i]               = p_valid[i];
      bus.req_last[i]                = p_last[i];
      bus.req_data[i*WIDTH +: WIDTH] = p_data[i];
    end
  endtask

  initial begin
    logic [NUM_REQ-1:0] exp_ready;
    bit                 exp_wr;
    logic [WIDTH-1:0]   exp_data;
    int                 owner_now;
    bit                 full_now;

    for (int i = 0; i < NUM_REQ; i++) begin
      p_valid[i] = 1'b0;
      p_last[i]  = 1'b0;
      p_data[i]  = '0;
      p_seq[i]   = 0;
    end
    reset         = 1'b1;
    bus.fifo_full = 1'b0;
    drive_bus();
    repeat (2) @(posedge clk);
    #1;

    for (int ph = 0; ph < 7; ph++) begin
      for (int c = 0; c < phases[ph].cycles; c++) begin
        reset         = ($urandom_range(99) < phases[ph].reset_pct);
        bus.fifo_full = ($urandom_range(99) < phases[ph].full_pct);
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!p_valid[i] && ($urandom_range(99) < phases[ph].valid_pct)) begin
            p_valid[i] = 1'b1;
            p_last[i]  = ($urandom_range(99) < phases[ph].last_pct);
            p_data[i]  = {$urandom, $urandom, $urandom, 8'(i), 24'(p_seq[i])};
          end
        end
        drive_bus();

        @(negedge clk);
        owner_now = m_owner;
        full_now  = bus.fifo_full;
        exp_ready = '0;
        exp_wr    = 1'b0;
        exp_data  = '0;
        if (owner_now >= 0) begin
          exp_ready[owner_now] = !full_now;
          if (p_valid[owner_now] && !full_now) begin
            exp_wr   = 1'b1;
            exp_data = p_data[owner_now];
          end
        end
        check_eq("req_ready",   WIDTH'(bus.req_ready), WIDTH'(exp_ready));
        check_eq("fifo_wr",     WIDTH'(bus.fifo_wr),   WIDTH'(exp_wr));
        check_eq("fifo_data",   bus.fifo_data,         exp_data);
        check_eq("busy",        WIDTH'(busy),          WIDTH'(owner_now >= 0));
        check_eq("grant_id",    WIDTH'(grant_id),      WIDTH'(m_last_gid));
        check_eq("burst_trunc", WIDTH'(burst_trunc),   WIDTH'(m_trunc));
        if (exp_wr)
          $display("t=%0t write req%0d seq=%0d last=%0b beat=%0d%s", $time, owner_now,
                   p_seq[owner_now], p_last[owner_now], m_beats + 1, reset ? " (reset)" : "");

        @(posedge clk);
        if (exp_wr) begin
          p_valid[owner_now] = 1'b0;
          p_seq[owner_now]++;
        end
        if (reset) begin
          m_owner    = -1;
          m_last_gid = 0;
          m_turn     = 0;
          m_beats    = 0;
          m_trunc    = 1'b0;
        end else begin
          m_trunc = 1'b0;
          if (owner_now < 0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
              if (m_owner < 0 && bus.req_valid[(m_turn + k) % NUM_REQ]) begin
                m_owner    = (m_turn + k) % NUM_REQ;
                m_last_gid = m_owner;
                m_beats    = 0;
              end
            end
          end else if (exp_wr) begin
            m_beats++;
            if (bus.req_last[owner_now] || m_beats == MAX_BURST) begin
              m_trunc = !bus.req_last[owner_now];
              m_turn  = (owner_now + 1) % NUM_REQ;
              m_owner = -1;
            end
          end
        end
        #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
